// File: rtl/wash_phase_timer_pkg.sv
// Shared washing-machine definitions: controller phase codes, timer FSM states
// and the timed-phase predicate. Imported by the controller and the phase timer.
package wm_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READY = 3'd1;
  localparam logic [2:0] SOAK  = 3'd2;
  localparam logic [2:0] WASH  = 3'd3;
  localparam logic [2:0] RINSE = 3'd4;
  localparam logic [2:0] SPIN  = 3'd5;

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_RUN   = 2'd1,
    T_PAUSE = 2'd2,
    T_DONE  = 2'd3
  } t_state_e;

  function automatic logic phase_is_timed(input logic [2:0] ph);
    return (ph >= SOAK) && (ph <= SPIN);
  endfunction

endpackage

// File: rtl/wash_phase_timer_if.sv
// Controller <-> phase-timer bundle. The controller (master) drives the phase
// code, lid sensor and cancel; the timer (slave) returns its status.
interface wash_phase_timer_if #(
  parameter int CNT_W = 16
);
  import wm_pkg::*;

  // No valid/ready here: sig_Time_Out is a single-cycle registered pulse that
  // the controller must consume on the cycle it is high; it is never held.
  logic [2:0]       state;
  logic             sig_Lid_Closed;
  logic             sig_Cancel;
  logic             sig_Time_Out;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic             paused;
  t_state_e         fsm_state;

  modport master (
    output state, sig_Lid_Closed, sig_Cancel,
    input  sig_Time_Out, remaining, busy, paused, fsm_state
  );

  modport slave (
    input  state, sig_Lid_Closed, sig_Cancel,
    output sig_Time_Out, remaining, busy, paused, fsm_state
  );

endinterface

// File: rtl/wash_phase_timer_prescaler.sv
// Divides the clock into duration units: tick is high while the count sits at
// TICK_DIV-1; the count wraps to 0 on the enabled cycle that consumes the tick.
module wpt_prescaler #(
  parameter int TICK_DIV = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/wash_phase_timer.sv
// Phase-duration timer: loads a per-phase duration on entry into a timed phase,
// counts it down on a prescaled tick and pulses sig_Time_Out on expiry.
// Optional lid pause is built when WPT_PAUSE_EN is defined.
module wash_phase_timer #(
  parameter int TICK_DIV  = 1000,
  parameter int CNT_W     = 16,
  parameter int SOAK_DUR  = 30,
  parameter int WASH_DUR  = 60,
  parameter int RINSE_DUR = 40,
  parameter int SPIN_DUR  = 20
) (
  input logic                clock,
  input logic                reset_n,
  wash_phase_timer_if.slave  bus
);
  import wm_pkg::*;

`ifdef WPT_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  t_state_e         fsm, fsm_nxt;
  logic [2:0]       prev_state;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             time_out, time_out_nxt;
  logic             phase_change, lid_open;
  logic             clear, enable, tick;

  function automatic logic [CNT_W-1:0] dur_of(input logic [2:0] ph);
    case (ph)
      SOAK:    return CNT_W'(SOAK_DUR);
      WASH:    return CNT_W'(WASH_DUR);
      RINSE:   return CNT_W'(RINSE_DUR);
      SPIN:    return CNT_W'(SPIN_DUR);
      default: return '0;
    endcase
  endfunction

  assign phase_change = (bus.state != prev_state);
  assign lid_open     = PAUSE_EN && !bus.sig_Lid_Closed;

  wpt_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear),
    .enable  (enable),
    .tick    (tick)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      fsm        <= T_IDLE;
      prev_state <= '0;
      remaining  <= '0;
      time_out   <= 1'b0;
    end else begin
      fsm        <= fsm_nxt;
      prev_state <= bus.state;
      remaining  <= remaining_nxt;
      time_out   <= time_out_nxt;
    end
  end

  always_comb begin
    fsm_nxt       = fsm;
    remaining_nxt = remaining;
    time_out_nxt  = 1'b0;
    clear         = 1'b0;
    enable        = 1'b0;
    if (bus.sig_Cancel) begin
      fsm_nxt       = T_IDLE;
      remaining_nxt = '0;
      clear         = 1'b1;
    end else if (phase_change) begin
      clear = 1'b1;
      if (phase_is_timed(bus.state)) begin
        fsm_nxt       = T_RUN;
        remaining_nxt = dur_of(bus.state);
      end else begin
        fsm_nxt       = T_IDLE;
        remaining_nxt = '0;
      end
    end else begin
      case (fsm)
        T_RUN, T_PAUSE: begin
          // Progress is frozen for exactly the cycles the lid is open; the
          // closing cycle both resumes and counts.
          if (lid_open) begin
            fsm_nxt = T_PAUSE;
          end else begin
            fsm_nxt = T_RUN;
            enable  = 1'b1;
            if (remaining == '0) begin
              time_out_nxt = 1'b1;
              fsm_nxt      = T_DONE;
            end else if (tick) begin
              remaining_nxt = remaining - 1'b1;
              if (remaining == CNT_W'(1)) begin
                time_out_nxt = 1'b1;
                fsm_nxt      = T_DONE;
              end
            end
          end
        end
        T_DONE:  remaining_nxt = '0;
        default: ;
      endcase
    end
  end

  assign bus.sig_Time_Out = time_out;
  assign bus.remaining    = remaining;
  assign bus.busy         = (fsm == T_RUN) || (fsm == T_PAUSE);
  assign bus.paused       = PAUSE_EN && (fsm == T_PAUSE);
  assign bus.fsm_state    = fsm;

endmodule

// File: tb/tb_wash_phase_timer.sv
// Bench for wash_phase_timer: directed phase scenarios plus random phase/cancel/
// lid/reset traffic checked cycle-by-cycle against an elapsed-time model.
module tb_wash_phase_timer;

  localparam int TICK_DIV  = 2;
  localparam int CNT_W     = 16;
  localparam int SOAK_DUR  = 0;
  localparam int WASH_DUR  = 3;
  localparam int RINSE_DUR = 5;
  localparam int SPIN_DUR  = 4;
  localparam int W         = CNT_W + 3;
`ifdef WPT_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  wash_phase_timer_if #(.CNT_W(CNT_W)) bus ();

  wash_phase_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W),
    .SOAK_DUR (SOAK_DUR),
    .WASH_DUR (WASH_DUR),
    .RINSE_DUR(RINSE_DUR),
    .SPIN_DUR (SPIN_DUR)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int dut_pulses = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is tracked as counted (unpaused) cycles since the last load; the
  // remaining count and the expiry point follow from plain arithmetic.
  int dur_tab[8] = '{0, 0, SOAK_DUR, WASH_DUR, RINSE_DUR, SPIN_DUR, 0, 0};
  bit m_active, m_paused, m_pulse;
  int m_dur, m_elapsed, m_rem, m_prev;

  task automatic model_update();
    int s;
    s = int'(bus.state);
    if (!reset_n) begin
      m_active = 0; m_paused = 0; m_pulse = 0; m_rem = 0; m_prev = 0;
    end else begin
      m_pulse = 0;
      if (bus.sig_Cancel) begin
        m_active = 0; m_paused = 0; m_rem = 0;
      end else if (s != m_prev) begin
        m_paused = 0;
        if (s >= 2 && s <= 5) begin
          m_active = 1; m_dur = dur_tab[s]; m_elapsed = 0; m_rem = m_dur;
        end else begin
          m_active = 0; m_rem = 0;
        end
      end else if (m_active) begin
        if (PAUSE_EN && !bus.sig_Lid_Closed) begin
          m_paused = 1;
        end else begin
          m_paused = 0;
          m_elapsed++;
          if (m_elapsed >= ((m_dur == 0) ? 1 : m_dur * TICK_DIV)) begin
            m_pulse = 1; m_active = 0; m_rem = 0;
          end else begin
            m_rem = m_dur - m_elapsed / TICK_DIV;
          end
        end
      end
      m_prev = s;
    end
    exp_q.push_back({m_pulse, m_active, m_paused, CNT_W'(m_rem)});
  endtask

  task automatic compare_outputs();
    logic [W-1:0] e;
    check("exp_q_size", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("time_out",  bus.sig_Time_Out, e[W-1]);
    check("busy",      bus.busy,         e[W-2]);
    check("paused",    bus.paused,       e[W-3]);
    check("remaining", bus.remaining,    e[CNT_W-1:0]);
    if (bus.sig_Time_Out) dut_pulses++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int s, input bit cancel, input bit lid, input bit rst_n);
    bus.state          = 3'(s);
    bus.sig_Cancel     = cancel;
    bus.sig_Lid_Closed = lid;
    reset_n            = rst_n;
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare_outputs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p0;
    int st;
    bit cancel, lid, rst_n;

    drive(0, 0, 1, 0);
    step(); step();
    check("rst_time_out",  bus.sig_Time_Out, 0);
    check("rst_remaining", bus.remaining, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_paused",    bus.paused, 0);

    // WASH from reset: load next edge, pulse six edges later
    drive(3, 0, 1, 1); step();
    check("wash_load", bus.remaining, WASH_DUR);
    check("wash_busy", bus.busy, 1);
    p0 = dut_pulses;
    repeat (5) step();
    check("wash_no_early_pulse", dut_pulses - p0, 0);
    step();
    check("wash_pulse",     bus.sig_Time_Out, 1);
    check("wash_done_rem",  bus.remaining, 0);
    check("wash_done_busy", bus.busy, 0);
    step();
    check("wash_pulse_width", bus.sig_Time_Out, 0);

    // phase change mid-count reloads, no stale pulse
    drive(0, 0, 1, 1); step();
    drive(3, 0, 1, 1); step(); step(); step();
    drive(4, 0, 1, 1); step();
    check("rinse_reload", bus.remaining, RINSE_DUR);
    p0 = dut_pulses;
    repeat (3) step();
    check("rinse_no_wash_pulse", dut_pulses - p0, 0);

    // cancel mid-count
    drive(0, 0, 1, 1); step();
    drive(3, 0, 1, 1); step();
    drive(3, 1, 1, 1); step();
    check("cancel_rem",  bus.remaining, 0);
    check("cancel_busy", bus.busy, 0);
    drive(3, 0, 1, 1);
    p0 = dut_pulses;
    repeat (12) step();
    check("cancel_no_pulse", dut_pulses - p0, 0);

    // zero-duration SOAK
    drive(0, 0, 1, 1); step();
    drive(2, 0, 1, 1); step();
    check("soak_rem",  bus.remaining, 0);
    check("soak_busy", bus.busy, 1);
    step();
    check("soak_pulse", bus.sig_Time_Out, 1);
    check("soak_done_busy", bus.busy, 0);
    p0 = dut_pulses;
    repeat (6) step();
    check("soak_single_pulse", dut_pulses - p0, 0);

    // untimed phases
    drive(1, 0, 1, 1); step();
    check("ready_rem",  bus.remaining, 0);
    check("ready_busy", bus.busy, 0);
    drive(6, 0, 1, 1); step();
    check("code6_rem",  bus.remaining, 0);
    check("code6_busy", bus.busy, 0);

    // reset mid-count, then re-entry straight out of reset
    drive(0, 0, 1, 1); step();
    drive(5, 0, 1, 1); step(); step(); step();
    drive(5, 0, 1, 0); step();
    check("midrst_rem",   bus.remaining, 0);
    check("midrst_busy",  bus.busy, 0);
    check("midrst_pulse", bus.sig_Time_Out, 0);
    drive(5, 0, 1, 1); step();
    check("spin_after_rst", bus.remaining, SPIN_DUR);

`ifdef WPT_PAUSE_EN
    drive(0, 0, 1, 1); step();
    drive(3, 0, 1, 1); step(); step(); step();
    check("pause_pre_rem", bus.remaining, 2);
    drive(3, 0, 0, 1);
    repeat (5) step();
    check("pause_paused", bus.paused, 1);
    check("pause_held",   bus.remaining, 2);
    drive(3, 0, 1, 1);
    p0 = dut_pulses;
    repeat (3) step();
    check("pause_no_early", dut_pulses - p0, 0);
    step();
    check("pause_delayed_pulse", bus.sig_Time_Out, 1);
`endif

    // random traffic against the model
    st = 0; lid = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) st = $urandom_range(0, 7);
      cancel = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0) lid = !lid;
      rst_n = ($urandom_range(0, 299) != 0);
      drive(st, cancel, lid, rst_n);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase-duration timer and sequencer for the washing-machine controller. Watches the controller's `state` code and loads a per-phase duration on every entry into a timed phase. Counts the duration down on a prescaled tick. Returns a one-cycle `sig_Time_Out` pulse to the controller when the phase expires. Sits between the controller and the clock, and replaces hand-driven `sig_Time_Out` stimulus.

## Interface
- `TICK_DIV`, 1000: clock cycles per duration unit; ≥1.
- `CNT_W`, 16: width of the remaining-time counter.
- `SOAK_DUR`, 30: SOAK duration in ticks.
- `WASH_DUR`, 60: WASH duration in ticks.
- `RINSE_DUR`, 40: RINSE duration in ticks.
- `SPIN_DUR`, 20: SPIN duration in ticks.

Ports:
- `clock` in 1: single clock; all logic on the rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `state` in 3: controller phase code.
- `sig_Lid_Closed` in 1: lid sensor; 1 = closed.
- `sig_Cancel` in 1: abort the current timing.
- `sig_Time_Out` out 1: one-cycle expiry pulse.
- `remaining` out CNT_W: ticks left in the current phase.
- `busy` out 1: timer is running or paused.
- `paused` out 1: countdown is frozen by an open lid.

## Operation
- Phase codes are fixed: IDLE=0, READY=1, SOAK=2, WASH=3, RINSE=4, SPIN=5. Codes 6–7 are untimed.
- Timed phases are 2–5. The duration of each is selected from its parameter.
- Internal FSM states: T_IDLE, T_RUN, T_PAUSE, T_DONE.
- `prev_state` register updates every cycle. `phase_change = (state != prev_state)`.
- Priority per cycle, highest first: reset, `sig_Cancel`, `phase_change`, pause/resume, tick/expiry.
- `sig_Cancel=1`:
  - FSM → T_IDLE, `remaining`←0, prescaler←0.
  - No pulse is generated.
- `phase_change` into a timed phase:
  - `remaining`←DUR, prescaler←0, FSM → T_RUN.
  - A pending expiry in the same cycle is discarded and no pulse is generated.
- `phase_change` into an untimed phase: FSM → T_IDLE, `remaining`←0.
- T_RUN:
  - Prescaler increments each cycle.
  - When prescaler = TICK_DIV−1: prescaler←0 and `remaining` decrements.
  - When the decrement reaches 0: `sig_Time_Out`=1 for exactly that cycle, FSM → T_DONE.
- DUR = 0: the timer enters T_RUN with `remaining`=0 and expires on the next cycle. It pulses once, then goes to T_DONE.
- T_DONE:
  - `remaining` holds 0.
  - No further pulses until the next `phase_change` or `sig_Cancel`.
- `remaining` never wraps. No decrement occurs at 0.
- `busy` = T_RUN or T_PAUSE. `paused` = T_PAUSE.

## Timing
- Reset values:
  - `sig_Time_Out`=0, `remaining`=0, `busy`=0, `paused`=0.
  - FSM=T_IDLE, prescaler=0, `prev_state`=0.
- Entering a timed phase right out of reset counts as a `phase_change`.
- Load latency: `state` changes before edge k; `remaining`=DUR is visible after edge k.
- Expiry: `sig_Time_Out` is high after edge k+DUR·TICK_DIV, for one cycle. The pause-free case applies.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-count: all outputs return to their reset values on that edge. No pulse is generated.

## Configuration
- `WPT_PAUSE_EN` defined:
  - In T_RUN with `sig_Lid_Closed`=0, the FSM goes to T_PAUSE. Prescaler and `remaining` freeze.
  - Lid closed again: the FSM returns to T_RUN and resumes from the frozen values, with no reload.
  - Expiry cannot occur in T_PAUSE.
  - `sig_Cancel` and `phase_change` still act while paused.
- `WPT_PAUSE_EN` undefined:
  - T_PAUSE is not built and `sig_Lid_Closed` is ignored.
  - `paused` is tied to 0.

## Structure
- Shared package `wm_pkg` holds:
  - the phase-code constants (IDLE…SPIN), shared with the controller;
  - the timer FSM state typedef;
  - a `phase_is_timed` function.
- One sub-module, `wpt_prescaler`:
  - inputs: `clock`, `reset_n`, `clear`, `enable`;
  - output: `tick`, high on count TICK_DIV−1.
  - The parent drives `clear` on load or cancel, and `enable` in T_RUN.

## Test plan
Settings: TICK_DIV=2, WASH_DUR=3, SOAK_DUR=0.
- Reset, then `state`=3 → `remaining`=3 one edge later. `sig_Time_Out` pulses after 6 edges; `remaining`=0 and `busy`=0 afterwards.
- `state`=3, then `state`=4 after 3 edges → `remaining` reloads to RINSE_DUR. No WASH pulse occurs.
- `state`=3, `sig_Cancel`=1 on edge 2 → `remaining`=0, FSM T_IDLE. No pulse ever follows.
- With `WPT_PAUSE_EN`: `state`=3, lid opened for 5 cycles after 2 edges → `paused`=1 and `remaining` held at 2. Pulse is delayed by exactly 5 cycles.
- `state`=2 (SOAK_DUR=0) → exactly one `sig_Time_Out` pulse on the second edge after entry, then T_DONE.
- `state`=1 or 6 → no load, `remaining`=0, `busy`=0.
